ram_block_arbiter: RTL and testbench

- Owns the single RAM port and shares it between NREQ block-transfer requesters, for example the coherence controller's data path and the instruction-fetch path.
- Sequences each granted request as one or two word accesses, waiting on the RAM ACCESS handshake for each word.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Uses round-robin arbitration so neither core starves the other.

---
 rtl/ram_block_arbiter_pkg.sv | 37 +++
 rtl/ram_block_arbiter_rr_arbiter2.sv | 22 ++
 rtl/ram_block_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_block_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_block_arbiter_pkg.sv
// Shared types for the RAM block arbiter: RAM handshake states, the
// arbiter FSM encoding and block geometry constants.
package ram_block_arbiter_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake state reported by the memory controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int unsigned BLK_BYTES = 8;
    localparam word_t       BLK_MASK  = 32'hFFFF_FFF8;
    localparam word_t       WORD_MASK = 32'hFFFF_FFFC;

    // Block-aligned base address of a byte address.
    function automatic word_t blk_base(input word_t a);
        return a & BLK_MASK;
    endfunction

    // Word-aligned address of a byte address.
    function automatic word_t word_align(input word_t a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/ram_block_arbiter_rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational; the last-grant pointer
// lives in the parent so the pick only advances when a grant is taken.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win,
    output logic       valid
);

    // A lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        win = '0;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
        valid = |req;
    end

endmodule

// File: rtl/ram_block_arbiter.sv
// Shares the single RAM port between two block-transfer requesters.
// Each grant is sequenced as one or two word accesses, each waiting on the
// RAM ACCESS handshake, and closes with a one-cycle done (and err) pulse.
module ram_block_arbiter
    import ram_block_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned BLK_WORDS = 2
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [NREQ-1:0]                      req,
    input  logic [NREQ-1:0]                      wen,
    input  logic [NREQ-1:0]                      single,
    input  word_t [NREQ-1:0]                     addr,
    input  word_t [NREQ-1:0][BLK_WORDS-1:0]      wdata,
    output logic [NREQ-1:0]                      gnt,
    output logic [NREQ-1:0]                      done,
    output logic [NREQ-1:0]                      err,
    output word_t [NREQ-1:0][BLK_WORDS-1:0]      rdata,
    output logic                                 ramREN,
    output logic                                 ramWEN,
    output word_t                                ramaddr,
    output word_t                                ramstore,
    input  word_t                                ramload,
    input  ramstate_t                            ramstate
);

    localparam word_t WORD_STEP = word_t'(BLK_BYTES / BLK_WORDS);

    arb_state_t                         state_q, state_d;
    logic [NREQ-1:0]                    gnt_q, gnt_d;
    logic                               last_q, last_d;
    logic                               err_q, err_d;
    word_t [NREQ-1:0][BLK_WORDS-1:0]    rdata_q, rdata_d;

    logic [1:0]                         pick_win;
    logic                               pick_valid;

    // Granted requester's transfer descriptor.
    logic                               sel;
    word_t                              sel_addr;
    logic                               sel_wen;
    logic                               sel_single;
    logic                               in_xfer;
    logic                               word_idx;

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // Decode which requester owns the port and which word is in flight.
    always_comb begin
        sel        = gnt_q[1];
        sel_addr   = addr[sel];
        sel_wen    = wen[sel];
        sel_single = single[sel];
        in_xfer    = (state_q == XFER0) || (state_q == XFER1);
        word_idx   = (state_q == XFER1);
    end

    // Next-state, grant, pointer, error latch and read-capture logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_win;
                    last_d  = pick_win[1];
                    err_d   = 1'b0;
                    state_d = XFER0;
                end
            end
            XFER0: begin
                if (ramstate == ACCESS) begin
                    if (!sel_wen) begin
                        rdata_d[sel][0] = ramload;
                    end
                    state_d = sel_single ? DONE : XFER1;
                end else if (ramstate == ERROR) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            XFER1: begin
                if (ramstate == ACCESS) begin
                    if (!sel_wen) begin
                        rdata_d[sel][1] = ramload;
                    end
                    state_d = DONE;
                end else if (ramstate == ERROR) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM port drive: enables and address only while a word is in flight.
    always_comb begin
        ramREN   = in_xfer && !sel_wen;
        ramWEN   = in_xfer && sel_wen;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == XFER0) begin
            ramaddr = sel_single ? word_align(sel_addr) : blk_base(sel_addr);
        end else if (state_q == XFER1) begin
            ramaddr = blk_base(sel_addr) + WORD_STEP;
        end
        if (in_xfer && sel_wen) begin
            ramstore = wdata[sel][word_idx];
        end
    end

    // Requester-side outputs; done/err only pulse in the DONE cycle.
    always_comb begin
        gnt   = gnt_q;
        rdata = rdata_q;
        done  = (state_q == DONE) ? gnt_q : '0;
        err   = ((state_q == DONE) && err_q) ? gnt_q : '0;
    end

endmodule

// File: tb/tb_ram_block_arbiter.sv
// Directed self-checking bench for ram_block_arbiter with a small RAM model.
module tb_ram_block_arbiter;
    import ram_block_arbiter_pkg::*;

    logic                 CLK;
    logic                 nRST;
    logic [1:0]           req, wen, single;
    word_t [1:0]          addr;
    word_t [1:0][1:0]     wdata;
    logic [1:0]           gnt, done, err;
    word_t [1:0][1:0]     rdata;
    logic                 ramREN, ramWEN;
    word_t                ramaddr, ramstore, ramload;
    ramstate_t            ramstate;

    word_t                mem [0:255];
    int                   checks;
    int                   failures;

    ram_block_arbiter #(.NREQ(2), .BLK_WORDS(2)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .req      (req),
        .wen      (wen),
        .single   (single),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ramload = mem[ramaddr[9:2]];

    always @(posedge CLK) begin
        if (ramWEN && ramstate == ACCESS) mem[ramaddr[9:2]] <= ramstore;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hAAAA_0001;   // 0x100
        mem[8'h41] = 32'hBBBB_0002;   // 0x104
        mem[8'hC0] = 32'h1111_0300;   // 0x300
        mem[8'hC1] = 32'h2222_0304;   // 0x304
        mem[8'h03] = 32'hEEEE_000C;   // 0x00C
        mem[8'h80] = 32'hF0F0_0200;   // 0x200
        mem[8'h81] = 32'h9999_0204;   // 0x204
        nRST = 1'b0; req = '0; wen = '0; single = '0; addr = '0; wdata = '0;
        ramstate = FREE;
        #12 nRST = 1'b1;
        tick();

        // Reset state
        chk("rst_gnt",    128'(gnt), 128'(0));
        chk("rst_done",   128'(done), 128'(0));
        chk("rst_err",    128'(err), 128'(0));
        chk("rst_en",     128'({ramREN, ramWEN}), 128'(0));
        chk("rst_addr",   128'(ramaddr), 128'(0));
        chk("rst_store",  128'(ramstore), 128'(0));
        chk("rst_rdata",  128'(rdata), 128'(0));

        // 1: block read by requester 0 at 0x104, ACCESS every cycle
        ramstate = ACCESS;
        req = 2'b01; addr[0] = 32'h104;
        #1 chk("t1_no_gnt_yet", 128'(gnt), 128'(0));
        tick();   // N+1 XFER0
        req = 2'b00;
        chk("t1_gnt",    128'(gnt), 128'(2'b01));
        chk("t1_en0",    128'({ramREN, ramWEN}), 128'(2'b10));
        chk("t1_addr0",  128'(ramaddr), 128'(32'h100));
        chk("t1_done0",  128'(done), 128'(0));
        tick();   // N+2 XFER1
        chk("t1_addr1",  128'(ramaddr), 128'(32'h104));
        chk("t1_rd0",    128'(rdata[0][0]), 128'(32'hAAAA_0001));
        chk("t1_done1",  128'(done), 128'(0));
        tick();   // N+3 DONE
        chk("t1_done",   128'(done), 128'(2'b01));
        chk("t1_err",    128'(err), 128'(0));
        chk("t1_en_off", 128'({ramREN, ramWEN}), 128'(0));
        chk("t1_rdata",  128'(rdata[0]), 128'({32'hBBBB_0002, 32'hAAAA_0001}));
        tick();   // IDLE
        chk("t1_idle_gnt",  128'(gnt), 128'(0));
        chk("t1_idle_done", 128'(done), 128'(0));

        // 2: block write by requester 1 at 0x20, two BUSY cycles before each ACCESS
        req = 2'b10; wen = 2'b10; addr[1] = 32'h20;
        wdata[1][0] = 32'hCCCC_0020; wdata[1][1] = 32'hDDDD_0024;
        ramstate = BUSY;
        tick();
        req = 2'b00;
        chk("t2_gnt", 128'(gnt), 128'(2'b10));
        for (int k = 1; k <= 6; k++) begin
            ramstate = (k % 3 == 0) ? ACCESS : BUSY;
            #1;
            chk("t2_en",    128'({ramREN, ramWEN}), 128'(2'b01));
            chk("t2_addr",  128'(ramaddr), 128'((k <= 3) ? 32'h20 : 32'h24));
            chk("t2_store", 128'(ramstore), 128'((k <= 3) ? 32'hCCCC_0020 : 32'hDDDD_0024));
            chk("t2_nodone", 128'(done), 128'(0));
            tick();
        end
        ramstate = ACCESS;
        chk("t2_done", 128'(done), 128'(2'b10));
        chk("t2_err",  128'(err), 128'(0));
        chk("t2_mem0", 128'(mem[8'h08]), 128'(32'hCCCC_0020));
        chk("t2_mem1", 128'(mem[8'h09]), 128'(32'hDDDD_0024));
        tick();
        wen = 2'b00;

        // 3: both requesting single reads continuously -> alternation
        single = 2'b11; addr[0] = 32'h300; addr[1] = 32'h304;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();   // XFER0
            chk("t3_gnt",  128'(gnt), 128'((i % 2 == 1) ? 2'b10 : 2'b01));
            tick();   // DONE
            chk("t3_done", 128'(done), 128'((i % 2 == 1) ? 2'b10 : 2'b01));
            if (i == 3) req = 2'b00;
            tick();   // IDLE
        end
        chk("t3_idle_gnt", 128'(gnt), 128'(0));
        chk("t3_rd0", 128'(rdata[0][0]), 128'(32'h1111_0300));
        chk("t3_rd1", 128'(rdata[1][0]), 128'(32'h2222_0304));

        // 4: single fetch at 0x00D (low bits ignored)
        single = 2'b01; req = 2'b01; addr[0] = 32'h00D;
        tick();   // XFER0
        req = 2'b00;
        chk("t4_addr", 128'(ramaddr), 128'(32'h00C));
        chk("t4_en",   128'({ramREN, ramWEN}), 128'(2'b10));
        tick();   // DONE at N+2
        chk("t4_done", 128'(done), 128'(2'b01));
        chk("t4_en_off", 128'({ramREN, ramWEN}), 128'(0));
        chk("t4_rdata", 128'(rdata[0]), 128'({32'hBBBB_0002, 32'hEEEE_000C}));
        tick();

        // 5: ERROR on word 1 of a block read by requester 1
        single = 2'b00; req = 2'b10; addr[1] = 32'h200;
        tick();   // XFER0
        req = 2'b00;
        chk("t5_addr0", 128'(ramaddr), 128'(32'h200));
        tick();   // XFER1
        ramstate = ERROR;
        #1 chk("t5_addr1", 128'(ramaddr), 128'(32'h204));
        tick();   // DONE
        ramstate = ACCESS;
        chk("t5_done",  128'(done), 128'(2'b10));
        chk("t5_err",   128'(err), 128'(2'b10));
        chk("t5_rdata", 128'(rdata[1]), 128'({32'h0, 32'hF0F0_0200}));
        tick();   // IDLE
        chk("t5_idle", 128'({gnt, done, err}), 128'(0));

        // 6: asynchronous reset during XFER1, then pending tie goes to 0
        req = 2'b01; addr[0] = 32'h104;
        tick();   // XFER0
        tick();   // XFER1
        chk("t6_pre_gnt", 128'(gnt), 128'(2'b01));
        chk("t6_pre_en",  128'({ramREN, ramWEN}), 128'(2'b10));
        req = 2'b11;
        #1 nRST = 1'b0;
        #1;
        chk("t6_rst_gnt",   128'(gnt), 128'(0));
        chk("t6_rst_en",    128'({ramREN, ramWEN}), 128'(0));
        chk("t6_rst_addr",  128'(ramaddr), 128'(0));
        chk("t6_rst_rdata", 128'(rdata), 128'(0));
        #1 nRST = 1'b1;
        tick();
        chk("t6_regrant", 128'(gnt), 128'(2'b01));
        req = 2'b00;
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
